// File: rtl/event_timestamper_pkg.sv
// event_timestamper_pkg: shared parameter defaults and sizing helper for the event timestamper
package event_timestamper_pkg;

    localparam int DEF_CLK_DIV  = 24;
    localparam int DEF_CNT_W    = 32;
    localparam int DEF_NUM_CH   = 2;
    localparam bit DEF_SATURATE = 1'b1;

    function automatic int presc_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/event_timestamper_capture.sv
// event_timestamper_capture: one channel's timestamp register with valid/ack handshake and sticky miss
module event_timestamper_capture #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_res,
    input  logic             i_clr,
    input  logic             i_evt,
    input  logic             i_ack,
    input  logic [CNT_W-1:0] i_cnt,
    output logic [CNT_W-1:0] o_ts,
    output logic             o_vld,
    output logic             o_miss
);

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            o_ts   <= '0;
            o_vld  <= 1'b0;
            o_miss <= 1'b0;
        end else begin
            // an ack in the same cycle frees the slot, so the new event is taken
            if (i_evt && (!o_vld || i_ack))
                o_ts <= i_cnt;
            if (i_evt)
                o_vld <= 1'b1;
            else if (i_ack)
                o_vld <= 1'b0;
            if (i_clr)
                o_miss <= 1'b0;
            else if (i_evt && o_vld && !i_ack)
                o_miss <= 1'b1;
        end
    end

endmodule

// File: rtl/event_timestamper.sv
// event_timestamper: prescaled timebase counter with per-channel event timestamp capture
module event_timestamper
    import event_timestamper_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter bit SATURATE = DEF_SATURATE
) (
    input  logic                    i_clk,
    input  logic                    i_res,
    input  logic                    i_cnt_clr,
    input  logic                    i_cnt_en,
    input  logic [NUM_CH-1:0]       i_evt,
    input  logic [NUM_CH-1:0]       i_ack,
    output logic                    o_tick,
    output logic [CNT_W-1:0]        o_cnt_val,
    output logic [NUM_CH*CNT_W-1:0] o_ts_val,
    output logic [NUM_CH-1:0]       o_ts_vld,
    output logic [NUM_CH-1:0]       o_miss,
    output logic                    o_wrap
);

    localparam int            PW   = presc_w(CLK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc;
    logic          tick;

    assign tick = i_cnt_en && (presc == PMAX);

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            presc  <= '0;
            o_tick <= 1'b0;
        end else begin
            o_tick <= tick;
            presc  <= (i_cnt_clr || !i_cnt_en || tick) ? '0 : presc + PW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            o_cnt_val <= '0;
            o_wrap    <= 1'b0;
        end else if (i_cnt_clr) begin
            o_cnt_val <= '0;
            o_wrap    <= 1'b0;
        end else if (tick) begin
            if (&o_cnt_val) begin
                if (!SATURATE) begin
                    o_cnt_val <= '0;
                    o_wrap    <= 1'b1;
                end
            end else begin
                o_cnt_val <= o_cnt_val + CNT_W'(1);
            end
        end
    end

    // every channel samples the pre-update count, so simultaneous events match
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        event_timestamper_capture #(
            .CNT_W (CNT_W)
        ) u_ch (
            .i_clk  (i_clk),
            .i_res  (i_res),
            .i_clr  (i_cnt_clr),
            .i_evt  (i_evt[k]),
            .i_ack  (i_ack[k]),
            .i_cnt  (o_cnt_val),
            .o_ts   (o_ts_val[k*CNT_W +: CNT_W]),
            .o_vld  (o_ts_vld[k]),
            .o_miss (o_miss[k])
        );
    end

endmodule

// File: tb/tb_event_timestamper.sv
// tb_event_timestamper: scoreboard bench for three timestamper configurations sharing one stimulus
module tb_event_timestamper;

    typedef struct packed {
        logic [63:0]      pre;
        logic [63:0]      cnt;
        logic             tick;
        logic             wrap;
        logic [1:0]       vld;
        logic [1:0]       miss;
        logic [1:0][63:0] ts;
    } st_t;

    logic       i_clk = 1'b0;
    logic       i_res = 1'b1;
    logic       i_cnt_clr = 1'b0;
    logic       i_cnt_en = 1'b0;
    logic [1:0] i_evt = 2'b00;
    logic [1:0] i_ack = 2'b00;

    logic        tick0, wrap0, tick1, wrap1, tick2, wrap2;
    logic [31:0] cnt0;
    logic [7:0]  cnt1, cnt2;
    logic [63:0] ts0;
    logic [15:0] ts1, ts2;
    logic [1:0]  vld0, miss0, vld1, miss1, vld2, miss2;

    int checks = 0;
    int errors = 0;
    int ncyc = 0;
    int tick_cnt = 0;
    int last_tick = -1;
    bit phase1 = 1'b0;
    int div_a [3] = '{24, 1, 1};
    int w_a [3] = '{32, 8, 8};
    bit sat_a [3] = '{1'b1, 1'b1, 1'b0};
    st_t m [3];
    st_t sb [$];

    event_timestamper u_def (
        .i_clk(i_clk), .i_res(i_res), .i_cnt_clr(i_cnt_clr), .i_cnt_en(i_cnt_en),
        .i_evt(i_evt), .i_ack(i_ack), .o_tick(tick0), .o_cnt_val(cnt0),
        .o_ts_val(ts0), .o_ts_vld(vld0), .o_miss(miss0), .o_wrap(wrap0)
    );

    event_timestamper #(.CLK_DIV(1), .CNT_W(8), .NUM_CH(2), .SATURATE(1'b1)) u_sat (
        .i_clk(i_clk), .i_res(i_res), .i_cnt_clr(i_cnt_clr), .i_cnt_en(i_cnt_en),
        .i_evt(i_evt), .i_ack(i_ack), .o_tick(tick1), .o_cnt_val(cnt1),
        .o_ts_val(ts1), .o_ts_vld(vld1), .o_miss(miss1), .o_wrap(wrap1)
    );

    event_timestamper #(.CLK_DIV(1), .CNT_W(8), .NUM_CH(2), .SATURATE(1'b0)) u_wrp (
        .i_clk(i_clk), .i_res(i_res), .i_cnt_clr(i_cnt_clr), .i_cnt_en(i_cnt_en),
        .i_evt(i_evt), .i_ack(i_ack), .o_tick(tick2), .o_cnt_val(cnt2),
        .o_ts_val(ts2), .o_ts_vld(vld2), .o_miss(miss2), .o_wrap(wrap2)
    );

    always #5 i_clk = ~i_clk;

    // reference: enabled-cycle phase, bounded integer count, per-channel slot state
    function automatic st_t step(input st_t s, input int div, input int w, input bit sat,
                                 input bit clr, input bit en, input logic [1:0] evt,
                                 input logic [1:0] ack);
        st_t n = s;
        logic [63:0] top = (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
        bit t = en && (s.pre == 64'(div - 1));
        n.tick = t;
        n.pre = (clr || !en || t) ? 64'd0 : s.pre + 64'd1;
        if (clr) begin
            n.cnt = 64'd0;
            n.wrap = 1'b0;
        end else if (t) begin
            if (s.cnt < top) n.cnt = s.cnt + 64'd1;
            else if (!sat) begin
                n.cnt = 64'd0;
                n.wrap = 1'b1;
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (evt[k]) begin
                if (!s.vld[k] || ack[k]) n.ts[k] = s.cnt;
                else n.miss[k] = 1'b1;
                n.vld[k] = 1'b1;
            end else if (ack[k]) begin
                n.vld[k] = 1'b0;
            end
            if (clr) n.miss[k] = 1'b0;
        end
        return n;
    endfunction

    function automatic st_t act(input int d);
        st_t a = '0;
        if (d == 0) begin
            a.cnt = 64'(cnt0); a.tick = tick0; a.wrap = wrap0; a.vld = vld0; a.miss = miss0;
            a.ts[0] = 64'(ts0[31:0]); a.ts[1] = 64'(ts0[63:32]);
        end else if (d == 1) begin
            a.cnt = 64'(cnt1); a.tick = tick1; a.wrap = wrap1; a.vld = vld1; a.miss = miss1;
            a.ts[0] = 64'(ts1[7:0]); a.ts[1] = 64'(ts1[15:8]);
        end else begin
            a.cnt = 64'(cnt2); a.tick = tick2; a.wrap = wrap2; a.vld = vld2; a.miss = miss2;
            a.ts[0] = 64'(ts2[7:0]); a.ts[1] = 64'(ts2[15:8]);
        end
        return a;
    endfunction

    always @(negedge i_clk) begin : mon
        st_t e, a;
        if (sb.size() >= 3) begin
            ncyc++;
            for (int d = 0; d < 3; d++) begin
                e = sb.pop_front();
                e.pre = '0;
                a = act(d);
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL sb dut%0d cyc%0d got cnt=%0h tick=%b wrap=%b vld=%b miss=%b ts=%0h/%0h want cnt=%0h tick=%b wrap=%b vld=%b miss=%b ts=%0h/%0h",
                             d, ncyc, a.cnt, a.tick, a.wrap, a.vld, a.miss, a.ts[0], a.ts[1],
                             e.cnt, e.tick, e.wrap, e.vld, e.miss, e.ts[0], e.ts[1]);
                end
            end
            if (tick0) begin
                if (phase1 && last_tick >= 0) begin
                    checks++;
                    if (ncyc - last_tick != 24) begin
                        errors++;
                        $display("FAIL tick_gap got %0d want 24", ncyc - last_tick);
                    end
                end
                last_tick = ncyc;
                tick_cnt++;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic cyc(input bit clr, input bit en, input logic [1:0] evt, input logic [1:0] ack);
        i_cnt_clr = clr;
        i_cnt_en = en;
        i_evt = evt;
        i_ack = ack;
        for (int d = 0; d < 3; d++) begin
            m[d] = step(m[d], div_a[d], w_a[d], sat_a[d], clr, en, evt, ack);
            sb.push_back(m[d]);
        end
        @(posedge i_clk);
        @(negedge i_clk);
        #1;
    endtask

    task automatic adv(input logic [63:0] target);
        for (int i = 0; i < 5000 && m[0].cnt != target; i++) cyc(1'b0, 1'b1, 2'b00, 2'b00);
        chk("adv_cnt", 64'(cnt0), target);
    endtask

    initial begin
        logic [63:0] v;
        int t0;
        for (int d = 0; d < 3; d++) m[d] = '0;
        repeat (3) @(negedge i_clk);
        chk("rst_cnt", 64'(cnt0), 64'd0);
        chk("rst_ts", ts0, 64'd0);
        chk("rst_flags", 64'({tick0, wrap0, vld0, miss0}), 64'd0);
        #1;
        i_res = 1'b0;

        phase1 = 1'b1;
        repeat (240) cyc(1'b0, 1'b1, 2'b00, 2'b00);
        cyc(1'b0, 1'b0, 2'b00, 2'b00);
        phase1 = 1'b0;
        chk("t1_cnt", 64'(cnt0), 64'd10);
        chk("t1_ticks", 64'(tick_cnt), 64'd10);

        t0 = tick_cnt;
        repeat (12) cyc(1'b0, 1'b1, 2'b00, 2'b00);
        repeat (5) cyc(1'b0, 1'b0, 2'b00, 2'b00);
        repeat (23) cyc(1'b0, 1'b1, 2'b00, 2'b00);
        chk("t2_no_early_tick", 64'(tick_cnt - t0), 64'd0);
        cyc(1'b0, 1'b1, 2'b00, 2'b00);
        chk("t2_one_tick", 64'(tick_cnt - t0), 64'd1);

        cyc(1'b1, 1'b0, 2'b00, 2'b00);
        repeat (300) cyc(1'b0, 1'b1, 2'b00, 2'b00);
        chk("t3_sat_cnt", 64'(cnt1), 64'd255);
        chk("t3_sat_wrap", 64'(wrap1), 64'd0);
        chk("t3_wrp_wrap", 64'(wrap2), 64'd1);
        cyc(1'b1, 1'b0, 2'b00, 2'b00);
        chk("t3_clr_wrap", 64'(wrap2), 64'd0);

        adv(64'd37);
        cyc(1'b0, 1'b1, 2'b01, 2'b00);
        chk("t4_ts", 64'(ts0[31:0]), 64'd37);
        chk("t4_vld", 64'(vld0[0]), 64'd1);
        cyc(1'b0, 1'b1, 2'b01, 2'b00);
        chk("t4_miss", 64'(miss0[0]), 64'd1);
        chk("t4_ts_held", 64'(ts0[31:0]), 64'd37);
        cyc(1'b0, 1'b1, 2'b00, 2'b01);
        chk("t4_ack_vld", 64'(vld0[0]), 64'd0);

        cyc(1'b1, 1'b0, 2'b00, 2'b00);
        chk("t5_miss_clr", 64'(miss0), 64'd0);
        adv(64'd49);
        cyc(1'b0, 1'b1, 2'b01, 2'b00);
        adv(64'd50);
        cyc(1'b0, 1'b1, 2'b01, 2'b01);
        chk("t5_b2b_ts", 64'(ts0[31:0]), 64'd50);
        chk("t5_b2b_vld_miss", 64'({vld0[0], miss0[0]}), 64'b10);
        v = m[0].cnt;
        cyc(1'b0, 1'b1, 2'b11, 2'b11);
        chk("t5_ch0", 64'(ts0[31:0]), v);
        chk("t5_ch1", 64'(ts0[63:32]), v);

        adv(64'd99);
        cyc(1'b1, 1'b1, 2'b10, 2'b10);
        chk("t6_ts_preclr", 64'(ts0[63:32]), 64'd99);
        chk("t6_cnt_clr", 64'(cnt0), 64'd0);
        cyc(1'b1, 1'b1, 2'b01, 2'b00);
        chk("t6_clr_beats_miss", 64'(miss0[0]), 64'd0);

        repeat (3000)
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, 2'($urandom), 2'($urandom));

        #2;
        i_res = 1'b1;
        #1;
        chk("arst_def", 64'({tick0, wrap0, vld0, miss0}) | 64'(cnt0) | ts0, 64'd0);
        chk("arst_sat", 64'({tick1, wrap1, vld1, miss1, cnt1, ts1}), 64'd0);
        chk("arst_wrp", 64'({tick2, wrap2, vld2, miss2, cnt2, ts2}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
